decode_pipe_stage: RTL and testbench

- Parametrised RISC-V instruction-decode pipeline stage: field extraction, immediate generation, main control decode and register-file read feed a registered ID/EX output slot.
- Adds a valid/ready handshake, load-use hazard stall, flush, and write-back-to-read bypass.
- Sits between the IF/ID register and the execute stage. The register file lives inside this block.

---
 rtl/decode_pipe_stage_if.sv | 45 ++++
 rtl/decode_pipe_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_decode_pipe_stage.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pipe_stage_if.sv
// Bundle between the IF/ID register, write-back, EX hazard info and the ID/EX slot.
// The upstream/execute side drives through master; the decode stage uses slave.
interface decode_pipe_stage_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            ex_memread;
  logic [4:0]      ex_rd;
  logic            flush;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [7:0]      out_ctrl;

  modport master (
    output in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data,
           ex_memread, ex_rd, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rs1, out_rs2, out_rd, out_funct3, out_funct7, out_ctrl
  );

  modport slave (
    input  in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data,
           ex_memread, ex_rd, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rs1, out_rs2, out_rd, out_funct3, out_funct7, out_ctrl
  );
endinterface

// File: rtl/decode_pipe_stage.sv
// RISC-V ID stage: decode, immediates, control, register file with WB bypass, registered ID/EX slot.
// Define ID_STALL_COUNTER_EN to add the saturating load-use stall counter output stall_count.
module decode_pipe_stage #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic               clk,
  input  logic               reset,
  decode_pipe_stage_if.slave bus
`ifdef ID_STALL_COUNTER_EN
  ,
  output logic [31:0]        stall_count
`endif
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // {illegal, Branch, MemRead/MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}.
  // MemtoReg is identical to MemRead for every class, so both share bit 5.
  localparam logic [7:0] CTRL_R       = 8'h11;
  localparam logic [7:0] CTRL_IALU    = 8'h03;
  localparam logic [7:0] CTRL_LOAD    = 8'h23;
  localparam logic [7:0] CTRL_STORE   = 8'h06;
  localparam logic [7:0] CTRL_BRANCH  = 8'h48;
  localparam logic [7:0] CTRL_U       = 8'h03;
  localparam logic [7:0] CTRL_J       = 8'h01;
  localparam logic [7:0] CTRL_ILLEGAL = 8'h80;

  logic [31:0]     w_instr;
  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [7:0]      w_ctrl;
  logic            w_use1;
  logic            w_use2;

  assign w_instr  = bus.in_instr;
  assign w_opcode = w_instr[6:0];

  always_comb begin
    w_rs1    = '0;
    w_rs2    = '0;
    w_rd     = '0;
    w_funct3 = '0;
    w_funct7 = '0;
    w_imm32  = '0;
    w_ctrl   = CTRL_ILLEGAL;
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_rs1    = w_instr[19:15];
        w_rs2    = w_instr[24:20];
        w_rd     = w_instr[11:7];
        w_funct3 = w_instr[14:12];
        w_funct7 = w_instr[31:25];
        w_use1   = 1'b1;
        w_use2   = 1'b1;
        w_ctrl   = CTRL_R;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        w_rs1    = w_instr[19:15];
        w_rd     = w_instr[11:7];
        w_funct3 = w_instr[14:12];
        w_imm32  = {{20{w_instr[31]}}, w_instr[31:20]};
        w_use1   = 1'b1;
        w_ctrl   = (w_opcode == OP_LOAD) ? CTRL_LOAD : CTRL_IALU;
      end
      OP_STORE: begin
        w_rs1    = w_instr[19:15];
        w_rs2    = w_instr[24:20];
        w_funct3 = w_instr[14:12];
        w_imm32  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
        w_use1   = 1'b1;
        w_use2   = 1'b1;
        w_ctrl   = CTRL_STORE;
      end
      OP_BRANCH: begin
        w_rs1    = w_instr[19:15];
        w_rs2    = w_instr[24:20];
        w_funct3 = w_instr[14:12];
        w_imm32  = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                    w_instr[30:25], w_instr[11:8], 1'b0};
        w_use1   = 1'b1;
        w_use2   = 1'b1;
        w_ctrl   = CTRL_BRANCH;
      end
      OP_LUI, OP_AUIPC: begin
        w_rd    = w_instr[11:7];
        w_imm32 = {w_instr[31:12], 12'b0};
        w_ctrl  = CTRL_U;
      end
      OP_JAL: begin
        w_rd    = w_instr[11:7];
        w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                   w_instr[20], w_instr[30:21], 1'b0};
        w_ctrl  = CTRL_J;
      end
      default: ;
    endcase
  end

  // All immediates are built as 32-bit values, then sign-extended to XLEN.
  assign w_imm = XLEN'($signed(w_imm32));

  logic [XLEN-1:0] r_rf [NREGS];
  logic            w_rs1_ok;
  logic            w_rs2_ok;
  logic            w_wb_we;
  logic [XLEN-1:0] w_rf_rs1;
  logic [XLEN-1:0] w_rf_rs2;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  assign w_rs1_ok = (w_rs1 != 5'd0) && ({27'd0, w_rs1} < 32'(NREGS));
  assign w_rs2_ok = (w_rs2 != 5'd0) && ({27'd0, w_rs2} < 32'(NREGS));
  assign w_wb_we  = bus.wb_en && (bus.wb_rd != 5'd0) && ({27'd0, bus.wb_rd} < 32'(NREGS));

  assign w_rf_rs1 = w_rs1_ok ? r_rf[w_rs1[AW-1:0]] : '0;
  assign w_rf_rs2 = w_rs2_ok ? r_rf[w_rs2[AW-1:0]] : '0;

  // Write-through: a result retiring this cycle is visible to the decode in the same cycle.
  assign w_rs1_data = (bus.wb_en && bus.wb_rd == w_rs1 && w_rs1 != 5'd0) ? bus.wb_data : w_rf_rs1;
  assign w_rs2_data = (bus.wb_en && bus.wb_rd == w_rs2 && w_rs2 != 5'd0) ? bus.wb_data : w_rf_rs2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_wb_we) begin
      r_rf[bus.wb_rd[AW-1:0]] <= bus.wb_data;
    end
  end

  logic w_hazard;
  logic w_slot_free;
  logic w_accept;
  logic r_out_valid;

  assign w_hazard = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                    ((w_use1 && bus.ex_rd == w_rs1) || (w_use2 && bus.ex_rd == w_rs2));
  assign w_slot_free  = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_slot_free && !w_hazard;
  assign w_accept     = bus.in_valid && bus.in_ready && !bus.flush;

  logic [XLEN-1:0] r_out_pc;
  logic [XLEN-1:0] r_out_rs1_data;
  logic [XLEN-1:0] r_out_rs2_data;
  logic [XLEN-1:0] r_out_imm;
  logic [4:0]      r_out_rs1;
  logic [4:0]      r_out_rs2;
  logic [4:0]      r_out_rd;
  logic [2:0]      r_out_funct3;
  logic [6:0]      r_out_funct7;
  logic [7:0]      r_out_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_out_pc       <= '0;
      r_out_rs1_data <= '0;
      r_out_rs2_data <= '0;
      r_out_imm      <= '0;
      r_out_rs1      <= '0;
      r_out_rs2      <= '0;
      r_out_rd       <= '0;
      r_out_funct3   <= '0;
      r_out_funct7   <= '0;
      r_out_ctrl     <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid    <= 1'b1;
      r_out_pc       <= bus.in_pc;
      r_out_rs1_data <= w_rs1_data;
      r_out_rs2_data <= w_rs2_data;
      r_out_imm      <= w_imm;
      r_out_rs1      <= w_rs1;
      r_out_rs2      <= w_rs2;
      r_out_rd       <= w_rd;
      r_out_funct3   <= w_funct3;
      r_out_funct7   <= w_funct7;
      r_out_ctrl     <= w_ctrl;
    end else if (w_slot_free) begin
      // Consumed with nothing new (including a load-use stall): emit a bubble.
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid    = r_out_valid;
  assign bus.out_pc       = r_out_pc;
  assign bus.out_rs1_data = r_out_rs1_data;
  assign bus.out_rs2_data = r_out_rs2_data;
  assign bus.out_imm      = r_out_imm;
  assign bus.out_rs1      = r_out_rs1;
  assign bus.out_rs2      = r_out_rs2;
  assign bus.out_rd       = r_out_rd;
  assign bus.out_funct3   = r_out_funct3;
  assign bus.out_funct7   = r_out_funct7;
  assign bus.out_ctrl     = r_out_ctrl;

`ifdef ID_STALL_COUNTER_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (bus.flush) begin
      r_stall_cnt <= '0;
    end else if (bus.in_valid && w_hazard && r_stall_cnt != 32'hFFFF_FFFF) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Scoreboard bench for decode_pipe_stage: directed test-plan cases, then random traffic
// checked against a class-level reference decoder and register model.
module tb_decode_pipe_stage;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_pipe_stage_if #(.XLEN(XLEN)) dif();
`ifdef ID_STALL_COUNTER_EN
  logic [31:0] stall_count;
`endif

  decode_pipe_stage #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif)
`ifdef ID_STALL_COUNTER_EN
    ,
    .stall_count(stall_count)
`endif
  );

  typedef struct {
    logic [XLEN-1:0] pc, rs1d, rs2d, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [7:0]      ctrl;
  } exp_t;

  typedef struct {
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
    logic [7:0]      ctrl;
    logic            u1, u2;
  } dec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic [XLEN-1:0] m_rf [32];
  logic        m_valid;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Classes: 0 illegal, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J.
  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    int   k, s, v;
    logic regwrite, alusrc, memwrite, memread, branch, illegal;
    logic [1:0] aluop;
    d = '{default: '0};
    case (ins[6:0])
      7'h33:               k = 1;
      7'h13, 7'h03, 7'h67: k = 2;
      7'h23:               k = 3;
      7'h63:               k = 4;
      7'h37, 7'h17:        k = 5;
      7'h6F:               k = 6;
      default:             k = 0;
    endcase
    s = int'(ins);
    d.u1  = (k >= 1 && k <= 4);
    d.u2  = (k == 1 || k == 3 || k == 4);
    d.rs1 = d.u1 ? ins[19:15] : 5'd0;
    d.rs2 = d.u2 ? ins[24:20] : 5'd0;
    d.rd  = (k == 1 || k == 2 || k == 5 || k == 6) ? ins[11:7] : 5'd0;
    d.f3  = (k >= 1 && k <= 4) ? ins[14:12] : 3'd0;
    d.f7  = (k == 1) ? ins[31:25] : 7'd0;
    case (k)
      2:       v = s >>> 20;
      3:       v = (s >>> 25) * 32 + int'(ins[11:7]);
      4:       v = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      5:       v = int'(ins & 32'hFFFF_F000);
      6:       v = (s >>> 31) * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      default: v = 0;
    endcase
    d.imm    = XLEN'(v);
    regwrite = (k == 1 || k == 2 || k == 5 || k == 6);
    alusrc   = (k == 2 || k == 3 || k == 5);
    memwrite = (k == 3);
    memread  = (ins[6:0] == 7'h03);
    branch   = (k == 4);
    illegal  = (k == 0);
    aluop    = (k == 1) ? 2'd2 : (k == 4) ? 2'd1 : 2'd0;
    d.ctrl   = {illegal, branch, memread, aluop, memwrite, alusrc, regwrite};
    return d;
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [4:0] r, input logic we,
                                             input logic [4:0] wrd, input logic [XLEN-1:0] wd);
    if (r == 5'd0) return '0;
    if (we && wrd == r) return wd;
    return m_rf[r];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    q.delete();
    m_valid = 1'b0;
    m_cnt   = '0;
  endtask

  // One clock of stimulus: drive after the falling edge, then advance the model
  // to the state the DUT will hold after the next rising edge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                       input logic ordy, input logic we, input logic [4:0] wrd,
                       input logic [XLEN-1:0] wd, input logic exm, input logic [4:0] exrd,
                       input logic fl);
    dec_t d;
    exp_t e;
    logic haz, free, rdy, acc;
    @(negedge clk);
    dif.in_valid   = v;
    dif.in_instr   = ins;
    dif.in_pc      = pc;
    dif.out_ready  = ordy;
    dif.wb_en      = we;
    dif.wb_rd      = wrd;
    dif.wb_data    = wd;
    dif.ex_memread = exm;
    dif.ex_rd      = exrd;
    dif.flush      = fl;
    #1;
    d    = ref_decode(ins);
    haz  = exm && exrd != 5'd0 && ((d.u1 && exrd == d.rs1) || (d.u2 && exrd == d.rs2));
    free = !m_valid || ordy;
    rdy  = free && !haz;
    acc  = v && rdy && !fl;
    chk("in_ready", 64'(dif.in_ready), 64'(rdy));
    chk("out_valid", 64'(dif.out_valid), 64'(m_valid));
`ifdef ID_STALL_COUNTER_EN
    chk("stall_count", 64'(stall_count), 64'(m_cnt));
`endif
    if (fl) m_cnt = '0;
    else if (v && haz && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (fl) begin
      q.delete();
      m_valid = 1'b0;
    end else if (acc) begin
      e.pc   = pc;
      e.rs1d = m_read(d.rs1, we, wrd, wd);
      e.rs2d = m_read(d.rs2, we, wrd, wd);
      e.imm  = d.imm;
      e.rs1  = d.rs1;
      e.rs2  = d.rs2;
      e.rd   = d.rd;
      e.f3   = d.f3;
      e.f7   = d.f7;
      e.ctrl = d.ctrl;
      q.push_back(e);
      m_valid = 1'b1;
    end else if (free) begin
      m_valid = 1'b0;
    end
    if (we && wrd != 5'd0) m_rf[wrd] = wd;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 32'h0, '0, ordy, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0);
  endtask

  // Monitor: every slot handed to EX must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset && dif.out_valid === 1'b1 && dif.out_ready && !dif.flush) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got a transfer pc=%h expected none", dif.out_pc);
      end else begin
        e = q.pop_front();
        chk("pc", 64'(dif.out_pc), 64'(e.pc));
        chk("rs1_data", 64'(dif.out_rs1_data), 64'(e.rs1d));
        chk("rs2_data", 64'(dif.out_rs2_data), 64'(e.rs2d));
        chk("imm", 64'(dif.out_imm), 64'(e.imm));
        chk("fields", 64'({dif.out_rs1, dif.out_rs2, dif.out_rd, dif.out_funct3, dif.out_funct7}),
                      64'({e.rs1, e.rs2, e.rd, e.f3, e.f7}));
        chk("ctrl", 64'(dif.out_ctrl), 64'(e.ctrl));
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] ins;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    ins        = $urandom;
    ins[6:0]   = ops[$urandom_range(0, 9)];
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  logic [XLEN-1:0] snap_pc, snap_imm;

  initial begin
    reset          = 1'b1;
    dif.in_valid   = 1'b0;
    dif.in_instr   = '0;
    dif.in_pc      = '0;
    dif.out_ready  = 1'b1;
    dif.wb_en      = 1'b0;
    dif.wb_rd      = '0;
    dif.wb_data    = '0;
    dif.ex_memread = 1'b0;
    dif.ex_rd      = '0;
    dif.flush      = 1'b0;
    model_clear();
    #2;
    chk("reset_in_ready", 64'(dif.in_ready), 64'd1);
    chk("reset_out_valid", 64'(dif.out_valid), 64'd0);
    chk("reset_out_pc", 64'(dif.out_pc), 64'd0);
    chk("reset_out_imm", 64'(dif.out_imm), 64'd0);
    chk("reset_out_ctrl", 64'(dif.out_ctrl), 64'd0);
    chk("reset_out_rs1_data", 64'(dif.out_rs1_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // ADDI x1,x0,-5
    drive(1'b1, 32'hFFB0_0093, XLEN'(64'h100), 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    chk("addi_valid", 64'(dif.out_valid), 64'd1);
    chk("addi_imm", 64'(dif.out_imm), 64'(XLEN'(64'hFFFF_FFFF_FFFF_FFFB)));
    chk("addi_rd", 64'(dif.out_rd), 64'd1);
    chk("addi_ctrl", 64'(dif.out_ctrl), 64'h03);

    // ADD x4,x3,x3 with a same-cycle write-back of x3
    drive(1'b1, 32'h0031_8233, XLEN'(64'h104), 1'b1, 1'b1, 5'd3, XLEN'(64'h1234), 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    chk("bypass_rs1", 64'(dif.out_rs1_data), 64'h1234);
    chk("bypass_rs2", 64'(dif.out_rs2_data), 64'h1234);
    // ADD x5,x3,x0 reads the stored value
    drive(1'b1, 32'h0001_82B3, XLEN'(64'h108), 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    chk("rf_read_x3", 64'(dif.out_rs1_data), 64'h1234);
    // ADD x1,x0,x0 while write-back targets x0
    drive(1'b1, 32'h0000_00B3, XLEN'(64'h10C), 1'b1, 1'b1, 5'd0, XLEN'(64'hDEAD), 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    chk("x0_bypass", 64'(dif.out_rs1_data), 64'd0);

    // Load-use: ADD x6,x5,x0 behind a load to x5
    drive(1'b1, 32'h0002_8333, XLEN'(64'h110), 1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd5, 1'b0);
    @(posedge clk); #1;
    chk("hazard_bubble", 64'(dif.out_valid), 64'd0);
`ifdef ID_STALL_COUNTER_EN
    chk("stall_count_one", 64'(stall_count), 64'd1);
`endif
    drive(1'b1, 32'h0002_8333, XLEN'(64'h110), 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    chk("hazard_accept", 64'(dif.out_valid), 64'd1);
    chk("hazard_rd", 64'(dif.out_rd), 64'd6);

    // LUI x7,0x80000
    drive(1'b1, 32'h8000_03B7, XLEN'(64'h114), 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    chk("lui_imm", 64'(dif.out_imm), 64'(XLEN'(64'hFFFF_FFFF_8000_0000)));
    snap_pc  = dif.out_pc;
    snap_imm = dif.out_imm;

    // Back-pressure for three cycles, then flush with a concurrent input
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hFFB0_0093, XLEN'(64'h200), 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0);
      @(posedge clk); #1;
      chk("hold_valid", 64'(dif.out_valid), 64'd1);
      chk("hold_pc", 64'(dif.out_pc), 64'(snap_pc));
      chk("hold_imm", 64'(dif.out_imm), 64'(snap_imm));
    end
    drive(1'b1, 32'hFFB0_0093, XLEN'(64'h204), 1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1);
    @(posedge clk); #1;
    chk("flush_valid", 64'(dif.out_valid), 64'd0);

    // Unrecognised opcode, then asynchronous reset mid-cycle
    drive(1'b1, 32'h0000_007F, XLEN'(64'h300), 1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    chk("illegal_ctrl", 64'(dif.out_ctrl), 64'h80);
    chk("illegal_imm", 64'(dif.out_imm), 64'd0);
    #1;
    dif.in_valid = 1'b0;
    dif.wb_en    = 1'b0;
    dif.flush    = 1'b0;
    dif.ex_memread = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 64'(dif.out_valid), 64'd0);
    chk("async_reset_ctrl", 64'(dif.out_ctrl), 64'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 3) != 0), rand_instr(), XLEN'({$urandom, $urandom}),
            ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), XLEN'({$urandom, $urandom}),
            ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 19) == 0));
    end
    for (int n = 0; n < 3; n++) idle(1'b1);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
